// File: rtl/game_state_ctrl_if.sv
// Control bus between the screen/game sequencer and the surrounding VGA logic.
interface game_state_ctrl_if;
  logic       vsync_in;
  logic       btn_jump;
  logic       collision;
  logic       start_en;
  logic       play_en;
  logic       end_en;
  logic       freeze;
  logic       game_rst;
  logic [1:0] state_out;

  // Environment side: drives timing/button/collision, observes enables
  modport master (
    output vsync_in, btn_jump, collision,
    input  start_en, play_en, end_en, freeze, game_rst, state_out
  );

  // Sequencer side
  modport slave (
    input  vsync_in, btn_jump, collision,
    output start_en, play_en, end_en, freeze, game_rst, state_out
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Screen/game sequencer: picks the active overlay layer and only switches on frame ticks.
module game_state_ctrl #(
  parameter int unsigned DEATH_FRAMES    = 30,
  parameter int unsigned END_HOLD_FRAMES = 60,
  parameter int unsigned CNT_W           = 8
) (
  input logic              clk,
  input logic              rst,
  game_state_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_END   = 2'd3
  } state_t;

  // Enable vector layout: {start_en, play_en, end_en, freeze}
  localparam logic [3:0] EN_START = 4'b1000;
  localparam logic [3:0] EN_PLAY  = 4'b0100;
  localparam logic [3:0] EN_DYING = 4'b0101;
  localparam logic [3:0] EN_END   = 4'b0111;

  localparam logic [CNT_W-1:0] DEATH_LOAD = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(END_HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       en;
  logic             vsync_d;
  logic             btn_d;
  logic             press_lat;
  logic             coll_lat;
  logic             game_rst_q;

  logic tick;
  logic press_now;
  logic coll_now;

  // An event arriving on the tick cycle itself counts for that tick
  assign tick      = bus.vsync_in & ~vsync_d;
  assign press_now = press_lat | (bus.btn_jump & ~btn_d);
  assign coll_now  = coll_lat | bus.collision;

  assign bus.start_en  = en[3];
  assign bus.play_en   = en[2];
  assign bus.end_en    = en[1];
  assign bus.freeze    = en[0];
  assign bus.game_rst  = game_rst_q;
  assign bus.state_out = state;

  // Sequencer: state, frame counter, event latches and enables all update together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_START;
      cnt        <= '0;
      en         <= EN_START;
      vsync_d    <= 1'b0;
      btn_d      <= 1'b0;
      press_lat  <= 1'b0;
      coll_lat   <= 1'b0;
      game_rst_q <= 1'b0;
    end else begin
      vsync_d    <= bus.vsync_in;
      btn_d      <= bus.btn_jump;
      game_rst_q <= 1'b0;
      press_lat  <= press_now;
      coll_lat   <= coll_now;
      if (tick) begin
        case (state)
          ST_START: begin
            if (press_now) begin
              state      <= ST_PLAY;
              en         <= EN_PLAY;
              game_rst_q <= 1'b1;
              press_lat  <= 1'b0;
              coll_lat   <= 1'b0;
            end
          end
          ST_PLAY: begin
            // Collision outranks a simultaneous press
            if (coll_now) begin
              state     <= ST_DYING;
              en        <= EN_DYING;
              cnt       <= DEATH_LOAD;
              press_lat <= 1'b0;
              coll_lat  <= 1'b0;
            end
          end
          ST_DYING: begin
            if (cnt == '0) begin
              state     <= ST_END;
              en        <= EN_END;
              cnt       <= HOLD_LOAD;
              press_lat <= 1'b0;
              coll_lat  <= 1'b0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: begin
            // Presses during the hold window are discarded so a held jump cannot restart
            if (cnt != '0) begin
              cnt       <= cnt - CNT_ONE;
              press_lat <= 1'b0;
            end else if (press_now) begin
              state     <= ST_START;
              en        <= EN_START;
              press_lat <= 1'b0;
              coll_lat  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: default parameters plus a DEATH=1/HOLD=1 instance.
module tb_game_state_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  game_state_ctrl_if bus ();
  game_state_ctrl_if bus2 ();

  // Second instance sees the same stimulus
  assign bus2.vsync_in  = bus.vsync_in;
  assign bus2.btn_jump  = bus.btn_jump;
  assign bus2.collision = bus.collision;

  game_state_ctrl #(
    .DEATH_FRAMES(30), .END_HOLD_FRAMES(60), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  game_state_ctrl #(
    .DEATH_FRAMES(1), .END_HOLD_FRAMES(1), .CNT_W(8)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One vsync rising edge; returns half a cycle after the tick edge
  task automatic tick();
    @(negedge clk) bus.vsync_in = 1'b1;
    @(negedge clk) bus.vsync_in = 1'b0;
  endtask

  task automatic press();
    @(negedge clk) bus.btn_jump = 1'b1;
    @(negedge clk) bus.btn_jump = 1'b0;
  endtask

  task automatic hit();
    @(negedge clk) bus.collision = 1'b1;
    @(negedge clk) bus.collision = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.vsync_in  = 1'b0;
    bus.btn_jump  = 1'b0;
    bus.collision = 1'b0;
    wait_cyc(2);
    check("rst_state", 32'(bus.state_out), 0);
    check("rst_start_en", 32'(bus.start_en), 1);
    check("rst_play_en", 32'(bus.play_en), 0);
    check("rst_game_rst", 32'(bus.game_rst), 0);
    rst = 1'b0;

    // Async reset in the middle of PLAY, checked before any clock edge
    press();
    tick();
    check("t1_play", 32'(bus.state_out), 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t1_async_state", 32'(bus.state_out), 0);
    check("t1_async_start", 32'(bus.start_en), 1);
    check("t1_async_play", 32'(bus.play_en), 0);
    @(negedge clk) rst = 1'b0;

    // vsync held high: a single tick, then nothing while a press accumulates
    @(negedge clk) bus.vsync_in = 1'b1;
    wait_cyc(3);
    press();
    wait_cyc(3);
    check("t2_hold_high", 32'(bus.state_out), 0);
    @(negedge clk) bus.vsync_in = 1'b0;
    wait_cyc(3);
    check("t2_hold_low", 32'(bus.state_out), 0);
    tick();
    check("t2_state", 32'(bus.state_out), 1);
    check("t2_game_rst", 32'(bus.game_rst), 1);
    check("t2_start_en", 32'(bus.start_en), 0);
    check("t2_play_en", 32'(bus.play_en), 1);
    @(negedge clk);
    check("t2_game_rst_1clk", 32'(bus.game_rst), 0);

    // Death timing: END exactly 30 ticks after DYING entry
    hit();
    wait_cyc(2);
    check("t3_mid_frame", 32'(bus.state_out), 1);
    tick();
    check("t3_dying", 32'(bus.state_out), 2);
    check("t3_freeze", 32'(bus.freeze), 1);
    check("t3_play_en", 32'(bus.play_en), 1);
    check("t3_end_en_early", 32'(bus.end_en), 0);
    repeat (29) tick();
    check("t3_still_dying", 32'(bus.state_out), 2);
    check("t3_end_en_29", 32'(bus.end_en), 0);
    tick();
    check("t3_end_state", 32'(bus.state_out), 3);
    check("t3_end_en_30", 32'(bus.end_en), 1);
    check("t3_end_start_en", 32'(bus.start_en), 0);

    // Hold window: presses before ticks 10 and 59 are discarded
    for (int t = 1; t <= 60; t++) begin
      if (t == 10 || t == 59) press();
      tick();
      if (t == 10 || t >= 59) check($sformatf("t4_hold_%0d", t), 32'(bus.state_out), 3);
    end
    press();
    wait_cyc(2);
    check("t4_wait_tick", 32'(bus.state_out), 3);
    tick();
    check("t4_start", 32'(bus.state_out), 0);
    check("t4_start_en", 32'(bus.start_en), 1);
    check("t4_end_en", 32'(bus.end_en), 0);
    check("t4_freeze", 32'(bus.freeze), 0);
    check("t4_play_en", 32'(bus.play_en), 0);
    check("t4_no_game_rst", 32'(bus.game_rst), 0);

    // Collision and press in the same frame: collision wins, no restart
    press();
    tick();
    check("t5_play", 32'(bus.state_out), 1);
    wait_cyc(2);
    hit();
    press();
    tick();
    check("t5_dying", 32'(bus.state_out), 2);
    check("t5_game_rst", 32'(bus.game_rst), 0);

    // Minimum parameter values on the second instance
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    press();
    tick();
    check("t6_play", 32'(bus2.state_out), 1);
    hit();
    tick();
    check("t6_dying", 32'(bus2.state_out), 2);
    check("t6_freeze", 32'(bus2.freeze), 1);
    tick();
    check("t6_end", 32'(bus2.state_out), 3);
    check("t6_end_en", 32'(bus2.end_en), 1);
    check("t6_dut1_dying", 32'(bus.state_out), 2);
    tick();
    check("t6_end_no_press", 32'(bus2.state_out), 3);
    press();
    tick();
    check("t6_restart", 32'(bus2.state_out), 0);
    check("t6_restart_en", 32'(bus2.start_en), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
